// File: rtl/obj_sched_pkg.sv
// Shared types and widths for the frame-synchronous object update scheduler.
package obj_sched_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    LATCH = 2'd1,
    REQ   = 2'd2,
    DONE  = 2'd3
  } sched_state_t;

  localparam logic [7:0]  KEY_PAUSE = 8'h13;
  localparam int unsigned FRAME_W   = 16;
  localparam int unsigned OVR_W     = 8;
  localparam int unsigned TMO_W     = 16;

endpackage

// File: rtl/vs_edge_sync.sv
// Two-flop synchronizer for the active-low vertical sync plus a falling-edge
// detector; frame_tick is a registered single-cycle pulse.
module vs_edge_sync (
  input  logic clk,
  input  logic rst,
  input  logic vs_n,
  output logic frame_tick
);

  logic sync1_q, sync1_d;
  logic sync2_q, sync2_d;
  logic hist_q, hist_d;
  logic tick_q, tick_d;

  always_comb begin
    sync1_d = vs_n;
    sync2_d = sync1_q;
    hist_d  = sync2_q;
    tick_d  = hist_q & ~sync2_q;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync1_q <= 1'b1;
      sync2_q <= 1'b1;
      hist_q  <= 1'b1;
      tick_q  <= 1'b0;
    end else begin
      sync1_q <= sync1_d;
      sync2_q <= sync2_d;
      hist_q  <= hist_d;
      tick_q  <= tick_d;
    end
  end

  assign frame_tick = tick_q;

endmodule

// File: rtl/obj_update_sched.sv
// Shares one object-update unit among NUM_OBJ objects, one pass per frame.
// Optional keyboard pause is enabled by defining OBJ_SCHED_PAUSE_EN.
module obj_update_sched
  import obj_sched_pkg::*;
#(
  parameter int unsigned NUM_OBJ = 4,
  parameter int unsigned IDX_W   = 2,
  parameter int unsigned TIMEOUT = 1023
) (
  input  logic                  Clk,
  input  logic                  Reset,
  input  logic                  frame_vs,
  input  logic [7:0]            keycode,
  output logic                  upd_req,
  output logic [IDX_W-1:0]      upd_idx,
  output logic [7:0]            upd_key,
  input  logic                  upd_ack,
  output logic                  frame_done,
  output logic [FRAME_W-1:0]    frame_count,
  output logic [OVR_W-1:0]      overrun_cnt,
  output logic                  stall_err
);

  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_OBJ - 1);
  localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(TIMEOUT - 1);

  logic frame_tick;

  vs_edge_sync u_sync (
    .clk        (Clk),
    .rst        (Reset),
    .vs_n       (frame_vs),
    .frame_tick (frame_tick)
  );

  sched_state_t       state_q, state_d;
  logic [IDX_W-1:0]   idx_q, idx_d;
  logic [TMO_W-1:0]   tmo_q, tmo_d;
  logic               req_q, req_d;
  logic [7:0]         key_q, key_d;
  logic               done_q, done_d;
  logic [FRAME_W-1:0] fcnt_q, fcnt_d;
  logic [OVR_W-1:0]   ovr_q, ovr_d;
  logic               stall_q, stall_d;
`ifdef OBJ_SCHED_PAUSE_EN
  logic               paused_q, paused_d;
`endif

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    tmo_d   = tmo_q;
    req_d   = 1'b0;
    key_d   = key_q;
    done_d  = 1'b0;
    fcnt_d  = fcnt_q;
    ovr_d   = ovr_q;
    stall_d = stall_q;
`ifdef OBJ_SCHED_PAUSE_EN
    paused_d = paused_q;
`endif

    case (state_q)
      IDLE: begin
        if (frame_tick) state_d = LATCH;
      end
      LATCH: begin
        key_d  = keycode;
        idx_d  = '0;
        tmo_d  = '0;
        fcnt_d = fcnt_q + 1'b1;
`ifdef OBJ_SCHED_PAUSE_EN
        // Toggle only on a fresh press; the previous frame's key is still in key_q.
        paused_d = paused_q ^ ((keycode == KEY_PAUSE) && (key_q != KEY_PAUSE));
        if (paused_d) begin
          state_d = DONE;
          done_d  = 1'b1;
        end else begin
          state_d = REQ;
          req_d   = 1'b1;
        end
`else
        state_d = REQ;
        req_d   = 1'b1;
`endif
      end
      REQ: begin
        req_d = 1'b1;
        if (upd_ack || (tmo_q == TMO_LAST)) begin
          if (!upd_ack) stall_d = 1'b1;
          if (idx_q == LAST_IDX) begin
            state_d = DONE;
            req_d   = 1'b0;
            done_d  = 1'b1;
          end else begin
            idx_d = idx_q + 1'b1;
            tmo_d = '0;
          end
        end else begin
          tmo_d = tmo_q + 1'b1;
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase

    if (frame_tick && (state_q != IDLE) && (ovr_q != '1)) ovr_d = ovr_q + 1'b1;
  end

  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      state_q  <= IDLE;
      idx_q    <= '0;
      tmo_q    <= '0;
      req_q    <= 1'b0;
      key_q    <= '0;
      done_q   <= 1'b0;
      fcnt_q   <= '0;
      ovr_q    <= '0;
      stall_q  <= 1'b0;
`ifdef OBJ_SCHED_PAUSE_EN
      paused_q <= 1'b0;
`endif
    end else begin
      state_q  <= state_d;
      idx_q    <= idx_d;
      tmo_q    <= tmo_d;
      req_q    <= req_d;
      key_q    <= key_d;
      done_q   <= done_d;
      fcnt_q   <= fcnt_d;
      ovr_q    <= ovr_d;
      stall_q  <= stall_d;
`ifdef OBJ_SCHED_PAUSE_EN
      paused_q <= paused_d;
`endif
    end
  end

  assign upd_req     = req_q;
  assign upd_idx     = idx_q;
  assign upd_key     = key_q;
  assign frame_done  = done_q;
  assign frame_count = fcnt_q;
  assign overrun_cnt = ovr_q;
  assign stall_err   = stall_q;

endmodule

// File: doc/obj_update_sched.md
# obj_update_sched

Frame-synchronous scheduler that shares one object-update unit (position/motion logic) among `NUM_OBJ` on-screen objects. Sits between the VGA timing generator and the motion datapath.

- On each vertical-sync falling edge, latches the current USB keycode.
- Issues one update request per object, in index order, through a req/ack handshake.
- Reports completion, dropped frames and stalled objects to the SoC status PIO.

## Interface
- `NUM_OBJ`, 4: number of objects sequenced per frame (2..16).
- `IDX_W`, 2: width of object index; must satisfy 2^`IDX_W` >= `NUM_OBJ`.
- `TIMEOUT`, 1023: cycles to wait for `upd_ack` before skipping an object (1..65535).
- `Clk` input 1: 50 MHz system clock; all logic on rising edge.
- `Reset` input 1: asynchronous, active-high reset.
- `frame_vs` input 1: VGA vertical sync, active low; synchronized internally.
- `keycode` input 8: USB HID keycode from the SoC.
- `upd_req` output 1: request to the update unit.
- `upd_idx` output `IDX_W`: object being updated; valid while `upd_req`.
- `upd_key` output 8: keycode latched for this frame; stable from LATCH until the next LATCH.
- `upd_ack` input 1: one-cycle completion pulse from the update unit.
- `frame_done` output 1: one-cycle pulse when a frame's sequence ends.
- `frame_count` output 16: accepted frames; wraps 0xFFFF -> 0.
- `overrun_cnt` output 8: frame ticks dropped while busy; saturates at 0xFF.
- `stall_err` output 1: sticky; set when any object times out.

## Operation
- **Synchronizer**
  - `frame_vs` passes through two flops, then a history flop.
  - `frame_tick` = history high AND synchronized low; one cycle wide.
- **State machine** (states IDLE, LATCH, REQ, DONE)
  - **IDLE**: on `frame_tick`, go to LATCH.
  - **LATCH**: capture `keycode` into `upd_key`; `idx` = 0; `tmo` = 0; increment `frame_count`; go to REQ.
  - **REQ**:
    - `upd_req` = 1, `upd_idx` = `idx`.
    - Each cycle without ack, `tmo` increments.
    - On ack, or on `tmo` == `TIMEOUT`-1:
      - timeout only: set `stall_err`.
      - If `idx` == `NUM_OBJ`-1, go to DONE.
      - Otherwise increment `idx`, clear `tmo`, stay in REQ with `upd_req` held high (back-to-back allowed).
  - **DONE**: `frame_done` = 1 for one cycle; go to IDLE.
- **Overrun**: `frame_tick` in any state other than IDLE increments `overrun_cnt` (saturating). The tick is dropped and the current sequence continues unaffected.
- **Ack outside REQ**: ignored.
- **Ack and timeout in the same cycle**: ack wins; `stall_err` is not set.
- **Reset mid-sequence**: immediate return to IDLE; `upd_req` drops asynchronously.
- **Reset values**:
  - `upd_req`, `frame_done`, `stall_err`: 0.
  - `upd_idx`, `upd_key`, `frame_count`, `overrun_cnt`: 0.
  - Sync flops: 1 (sync inactive).

## Timing
- `frame_tick` asserts 3 `Clk` edges after the first edge that samples `frame_vs` low.
- `frame_tick` -> LATCH: next cycle. LATCH -> first `upd_req`: next cycle.
- Minimum frame sequence, with ack in the first REQ cycle for every object: `NUM_OBJ` + 2 cycles from LATCH to `frame_done`.
- Maximum frame sequence, every object timing out: 2 + `NUM_OBJ`×`TIMEOUT` cycles.
- `upd_idx` changes only on the edge after an ack or timeout.
- All outputs are registered.

## Configuration
- Macro: `OBJ_SCHED_PAUSE_EN`.
- **Defined**:
  - In LATCH, if `keycode` == 8'h13 ('P') and the previous frame's latched key was not 8'h13, toggle `paused`.
  - When `paused`, LATCH goes directly to DONE: no requests issued, `frame_count` still increments.
  - `paused` resets to 0.
- **Undefined**: no pause logic; keycode is only latched and forwarded.

## Structure
- Package `obj_sched_pkg`:
  - State enum `sched_state_t`.
  - `KEY_PAUSE` = 8'h13.
  - Counter widths: frame 16, overrun 8, timeout 16.
- Sub-module `vs_edge_sync`: two-flop synchronizer plus falling-edge detect; emits `frame_tick`.
- Scheduler FSM, counters and status registers stay in the top level.

## Test plan
- Reset, then one `frame_vs` falling edge, update unit acks 2 cycles after each req, `NUM_OBJ`=4 -> `upd_idx` sequence 0,1,2,3; one `frame_done` pulse; `frame_count`=1; `stall_err`=0.
- Ack held high continuously -> 4 back-to-back grants; `frame_done` 6 cycles after LATCH.
- No ack, `TIMEOUT`=8 -> each object waits 8 cycles; `stall_err`=1 after object 0; `frame_done` still pulses.
- Second `frame_vs` falling edge during REQ -> `overrun_cnt`=1; `frame_count` unchanged until the next IDLE tick; after 300 overruns `overrun_cnt`=0xFF.
- Assert `Reset` while `upd_idx`=2 -> `upd_req` falls before the next `Clk` edge; all outputs 0; the next frame starts at idx 0.
- With `OBJ_SCHED_PAUSE_EN`: `keycode`=8'h13 for frames 1–3 -> paused after frame 1 only; frames 1–3 issue no `upd_req`. Keycode 0 on frame 4, then 8'h13 on frame 5 -> unpaused; frame 5 issues 4 requests.
